uart_cmd_responder: RTL and testbench

//  Host-side command engine for the uart block. Pops command bytes from the uart RX FIFO,

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_cmd_xsum.sv | 21 ++
 rtl/uart_cmd_responder.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcodes, NAK byte, FSM states and header lengths for the uart command engine (UART_CMD_CHECKSUM_EN adds checksum states)
package uart_cmd_pkg;
    localparam logic [7:0] OP_ECHO  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] NAK      = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_ECHO, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_ERR_SEND
`ifdef UART_CMD_CHECKSUM_EN
        , S_CHK, S_CSUM_SEND
`endif
    } state_t;

    function automatic logic [2:0] hdr_len(input logic [7:0] op);
        return (op == OP_ECHO) ? 3'd1 : 3'd4;
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_WRITE) || (op == OP_READ);
    endfunction
endpackage

// File: rtl/uart_cmd_xsum.sv
// uart_cmd_xsum: 8-bit XOR accumulator; clear and accumulate together loads the input byte
module uart_cmd_xsum (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_acc,
    input  logic [7:0] i_d,
    output logic [7:0] o_x
);
    logic [7:0] r_x;

    // Running XOR of accepted bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_x <= 8'h00;
        else if (i_clr || i_acc)
            r_x <= (i_clr ? 8'h00 : r_x) ^ (i_acc ? i_d : 8'h00);
    end

    assign o_x = r_x;
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: RX-FIFO command parser driving a byte memory bus and TX-FIFO replies (UART_CMD_CHECKSUM_EN enables packet checksums)
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_empty,
    output logic                 rd_en,
    output logic [7:0]           tx_data,
    output logic                 wr_en,
    input  logic                 tx_full,
    output logic [ADDR_BITS-1:0] mem_a,
    output logic [7:0]           mem_dout,
    output logic                 mem_wr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_din,
    output logic                 busy,
    output logic                 cmd_err
);
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t S_RD_DONE = S_CSUM_SEND;
`else
    localparam state_t S_RD_DONE = S_IDLE;
`endif

    state_t               r_state;
    logic [7:0]           r_op;
    logic [2:0]           r_idx;
    logic [LEN_BITS-1:0]  r_len;
    logic [ADDR_BITS-1:0] r_addr;
    logic [7:0]           r_tx;
    logic                 r_err;
    logic                 w_rx_ok;
    logic                 w_echo_go;
    logic                 w_send;
    logic [LEN_BITS-1:0]  w_len_new;

    function automatic state_t f_data(input logic [7:0] op, input logic [LEN_BITS-1:0] len);
        if (len == '0)
            return (op == OP_READ) ? S_RD_DONE : S_IDLE;
        return (op == OP_ECHO) ? S_ECHO : (op == OP_WRITE) ? S_WR : S_RD_REQ;
    endfunction

    assign w_rx_ok   = !rx_empty && !reset;
    assign w_echo_go = (r_state == S_ECHO) && w_rx_ok && !tx_full;
    assign w_len_new = (r_op == OP_ECHO) ? LEN_BITS'(rx_data) : LEN_BITS'({rx_data, r_len[7:0]});
    assign rd_en     = w_echo_go || (w_rx_ok && (r_state == S_IDLE || r_state == S_HDR || r_state == S_WR
`ifdef UART_CMD_CHECKSUM_EN
                       || r_state == S_CHK
`endif
                       ));
    assign w_send    = !tx_full && (r_state == S_RD_SEND || r_state == S_ERR_SEND
`ifdef UART_CMD_CHECKSUM_EN
                       || r_state == S_CSUM_SEND
`endif
                       );
    assign wr_en     = w_echo_go || w_send;
    assign mem_wr    = (r_state == S_WR) && w_rx_ok;
    assign mem_dout  = (r_state == S_WR) ? rx_data : 8'h00;
    assign mem_rd    = r_state == S_RD_REQ;
    assign mem_a     = r_addr;
    assign busy      = r_state != S_IDLE;
    assign cmd_err   = r_err;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] w_xsum;

    uart_cmd_xsum u_xsum (
        .clk   (clk),
        .reset (reset),
        .i_clr (!rx_empty && (r_state == S_IDLE || r_state == S_CHK)),
        .i_acc ((!rx_empty && (r_state == S_IDLE || r_state == S_HDR)) || (r_state == S_RD_SEND && !tx_full)),
        .i_d   ((r_state == S_RD_SEND) ? r_tx : rx_data),
        .o_x   (w_xsum)
    );

    assign tx_data = (r_state == S_ECHO) ? rx_data : (r_state == S_CSUM_SEND) ? w_xsum : r_tx;
`else
    assign tx_data = (r_state == S_ECHO) ? rx_data : r_tx;
`endif

    // Packet parser and data-phase sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 8'h00;
            r_idx   <= 3'd0;
            r_len   <= '0;
            r_addr  <= '0;
            r_tx    <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (!rx_empty) begin
                    r_op  <= rx_data;
                    r_idx <= 3'd0;
                    if (op_known(rx_data)) begin
                        r_state <= S_HDR;
                    end else begin
                        r_err   <= 1'b1;
                        r_tx    <= NAK;
                        r_state <= S_ERR_SEND;
                    end
                end
                S_HDR: if (!rx_empty) begin
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd0) r_addr <= ADDR_BITS'(rx_data);
                    if (r_idx == 3'd1) r_addr <= ADDR_BITS'({rx_data, r_addr[7:0]});
                    if (r_idx == 3'd2) r_len <= LEN_BITS'(rx_data);
                    if (r_idx == hdr_len(r_op) - 3'd1) begin
                        r_len <= w_len_new;
`ifdef UART_CMD_CHECKSUM_EN
                        r_state <= S_CHK;
`else
                        r_state <= f_data(r_op, w_len_new);
`endif
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_CHK: if (!rx_empty) begin
                    if (rx_data == w_xsum) begin
                        r_state <= f_data(r_op, r_len);
                    end else begin
                        r_err   <= 1'b1;
                        r_tx    <= NAK;
                        r_state <= S_ERR_SEND;
                    end
                end
                S_CSUM_SEND: if (!tx_full) r_state <= S_IDLE;
`endif
                S_ECHO: if (w_echo_go) begin
                    r_len   <= r_len - 1'b1;
                    r_state <= (r_len == LEN_BITS'(1)) ? S_IDLE : S_ECHO;
                end
                S_WR: if (!rx_empty) begin
                    r_addr  <= r_addr + 1'b1;
                    r_len   <= r_len - 1'b1;
                    r_state <= (r_len == LEN_BITS'(1)) ? S_IDLE : S_WR;
                end
                S_RD_REQ: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_tx    <= mem_din;
                    r_state <= S_RD_SEND;
                end
                S_RD_SEND: if (!tx_full) begin
                    r_addr  <= r_addr + 1'b1;
                    r_len   <= r_len - 1'b1;
                    r_state <= (r_len == LEN_BITS'(1)) ? S_RD_DONE : S_RD_REQ;
                end
                S_ERR_SEND: if (!tx_full) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: table-driven packet bench with RX/TX FIFO and memory models plus a response scoreboard
module tb_uart_cmd_responder;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        logic [95:0] pkt;
        int          n;
        logic [31:0] rsp;
        int          nr;
        logic [15:0] wa;
        logic [31:0] wd;
        int          nw;
        logic [15:0] ra;
        int          nrd;
        logic        err;
        int          full;
        int          rem;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rd_en;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic        tx_full = 1'b0;
    logic [15:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_din = 8'h00;
    logic        busy;
    logic        cmd_err;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_wd[$];
    logic [15:0] exp_wa[$];
    logic [15:0] exp_ra[$];
    logic [7:0]  mem [0:65535];
    logic        tx_block = 1'b0;
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_val = 8'h00;
    logic [7:0]  tmp;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vq[$];
    vec_t        v;

    always #5 clk = ~clk;

    uart_cmd_responder #(.ADDR_BITS(16), .LEN_BITS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rd_en    (rd_en),
        .tx_data  (tx_data),
        .wr_en    (wr_en),
        .tx_full  (tx_full),
        .mem_a    (mem_a),
        .mem_dout (mem_dout),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .mem_din  (mem_din),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h, expected no transfer", nm, act);
    endtask

    function automatic vec_t mkv(input logic [95:0] p, input int n, input logic [31:0] r, input int nr, input logic e);
        vec_t t;
        t.pkt = p; t.n = n; t.rsp = r; t.nr = nr; t.err = e;
        t.wa = 16'h0; t.wd = 32'h0; t.nw = 0; t.ra = 16'h0; t.nrd = 0; t.full = 0; t.rem = 0;
        return t;
    endfunction

    // Handshake monitor: samples DUT strobes mid-cycle, models FIFOs and memory, checks scoreboard
    always @(negedge clk) begin
        if (rd_en) begin
            chk("rd_when_empty", 64'(rx_empty), 64'(0));
            if (rx_q.size() > 0) tmp = rx_q.pop_front();
        end
        if (wr_en) begin
            chk("wr_when_full", 64'(tx_full), 64'(0));
            if (exp_tx.size() == 0) unexpected("tx_byte", 64'(tx_data));
            else chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
        end
        if (mem_wr) begin
            mem[mem_a] = mem_dout;
            if (exp_wa.size() == 0) unexpected("mem_wr", 64'(mem_a));
            else begin
                chk("wr_addr", 64'(mem_a), 64'(exp_wa.pop_front()));
                chk("wr_data", 64'(mem_dout), 64'(exp_wd.pop_front()));
            end
        end
        if (mem_rd) begin
            rd_val  = mem[mem_a];
            rd_pend = 1'b1;
            if (exp_ra.size() == 0) unexpected("mem_rd", 64'(mem_a));
            else chk("rd_addr", 64'(mem_a), 64'(exp_ra.pop_front()));
        end
    end

    // Input driver: updates FIFO flags and read data just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            mem_din = rd_val;
            rd_pend = 1'b0;
        end
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
        tx_full  = tx_block;
    end

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((rx_q.size() > 0 || exp_tx.size() > 0 || exp_wa.size() > 0 || exp_ra.size() > 0 || busy) && k < 400) begin
            @(negedge clk); #2;
            k++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk({nm, "_timeout"}, 64'(k >= 400), 64'(0));
        chk({nm, "_leftover"}, 64'(rx_q.size() + exp_tx.size() + exp_wa.size() + exp_ra.size()), 64'(0));
        chk({nm, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic apply(input vec_t t, input string nm);
        for (int j = 0; j < t.nr; j++) exp_tx.push_back(t.rsp[8*j +: 8]);
        for (int j = 0; j < t.nw; j++) begin
            exp_wa.push_back(16'(t.wa + 16'(j)));
            exp_wd.push_back(t.wd[8*j +: 8]);
        end
        for (int j = 0; j < t.nrd; j++) exp_ra.push_back(16'(t.ra + 16'(j)));
        tx_block = (t.full > 0);
        for (int j = 0; j < t.n; j++) rx_q.push_back(t.pkt[8*j +: 8]);
        if (t.full > 0) begin
            repeat (t.full) @(negedge clk);
            #2;
            chk({nm, "_rx_left_while_full"}, 64'(rx_q.size()), 64'(t.rem));
            chk({nm, "_tx_pending_while_full"}, 64'(exp_tx.size()), 64'(t.nr));
            tx_block = 1'b0;
        end
        wait_idle(nm);
        chk({nm, "_cmd_err"}, 64'(cmd_err), 64'(t.err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5C;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", 64'({rd_en, wr_en, mem_wr, mem_rd, busy, cmd_err, tx_data, mem_a, mem_dout}), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        v = CS ? mkv(96'h434241030300, 6, 32'h434241, 3, 1'b0) : mkv(96'h4342410300, 5, 32'h434241, 3, 1'b0);
        v.full = 6; v.rem = 3; vq.push_back(v);
        v = CS ? mkv(96'hCCBBAA030003FFFE01, 9, 32'h0, 0, 1'b0) : mkv(96'hCCBBAA0003FFFE01, 8, 32'h0, 0, 1'b0);
        v.wa = 16'hFFFE; v.wd = 32'hCCBBAA; v.nw = 3; vq.push_back(v);
        v = CS ? mkv(96'h000003FFFE02, 6, 32'hDDCCBBAA, 4, 1'b0) : mkv(96'h0003FFFE02, 5, 32'hCCBBAA, 3, 1'b0);
        v.ra = 16'hFFFE; v.nrd = 3; vq.push_back(v);
        vq.push_back(mkv(96'h7F, 1, 32'hEE, 1, 1'b1));
        vq.push_back(CS ? mkv(96'h55010100, 4, 32'h55, 1, 1'b1) : mkv(96'h550100, 3, 32'h55, 1, 1'b1));
        vq.push_back(mkv(96'h0, CS ? 3 : 2, 32'h0, 0, 1'b1));
        vq.push_back(CS ? mkv(96'h270000123401, 6, 32'h0, 0, 1'b1) : mkv(96'h0000123401, 5, 32'h0, 0, 1'b1));
        vq.push_back(CS ? mkv(96'h020000000002, 6, 32'h00, 1, 1'b1) : mkv(96'h02, 5, 32'h0, 0, 1'b1));
`ifdef UART_CMD_CHECKSUM_EN
        vq.push_back(mkv(96'h99110001001001, 7, 32'hEEEE, 2, 1'b1));
`endif
        for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

        chk("mem_FFFE", 64'(mem[16'hFFFE]), 64'hAA);
        chk("mem_0000", 64'(mem[16'h0000]), 64'hCC);

        apply(CS ? mkv(96'h6201010061010100, 8, 32'h6261, 2, 1'b1) : mkv(96'h620100610100, 6, 32'h6261, 2, 1'b1), "back2back");

        v = CS ? mkv(96'h070004010002, 6, 32'h5C, 1, 1'b0) : mkv(96'h0004010002, 5, 32'h5C, 1, 1'b0);
        exp_tx.push_back(8'h5C);
        exp_ra.push_back(16'h0100);
        for (int j = 0; j < v.n; j++) rx_q.push_back(v.pkt[8*j +: 8]);
        k = 0;
        while (exp_tx.size() > 0 && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        chk("midread_timeout", 64'(k >= 100), 64'(0));
        reset = 1'b1;
        #1;
        chk("midread_reset_outs", 64'({rd_en, wr_en, mem_wr, mem_rd, busy, cmd_err, tx_data, mem_a, mem_dout}), 64'(0));
        rx_q.delete(); exp_tx.delete(); exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply(CS ? mkv(96'h5A010100, 4, 32'h5A, 1, 1'b0) : mkv(96'h5A0100, 3, 32'h5A, 1, 1'b0), "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
